// File: rtl/rx_frame_queue.sv
// Store-and-forward RX frame queue: frames become visible downstream only once committed.
// Statistics counters are built only when RXQ_STATS_EN is defined; otherwise the stat ports read 0.

module rx_frame_queue #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [ADDR_W:0]   frames_pending,
  output logic [CNT_W-1:0]  stat_good,
  output logic [CNT_W-1:0]  stat_err,
  output logic [CNT_W-1:0]  stat_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   PEND_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {SYNC, IDLE, WRITE, DROP} wr_state_e;

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W:0]   pending_q;

  logic [8:0] mem_q [DEPTH];
  logic [8:0] ram_rdata_q;
  logic       ram_valid_q;
  logic [7:0] tdata_q;
  logic       tlast_q;
  logic       tvalid_q;

  logic full;
  logic mem_we;
  logic commit;
  logic err_inc;
  logic ovf_inc;
  logic drain;
  logic out_load;
  logic fetch;
  logic pending_dec;

  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_inc == rd_ptr_q);

  // Write FSM: a rolled-back frame simply rewinds wr_ptr to the last commit point.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    err_inc      = 1'b0;
    ovf_inc      = 1'b0;
    case (state_q)
      SYNC: begin
        if (!s_axis_tvalid) state_d = IDLE;
      end
      IDLE, WRITE: begin
        if (s_axis_tvalid) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            if (s_axis_tlast) begin
              state_d = IDLE;
              if (!s_axis_tuser) begin
                commit_ptr_d = wr_ptr_inc;
                commit       = 1'b1;
              end else begin
                wr_ptr_d = commit_ptr_q;
                err_inc  = 1'b1;
              end
            end else begin
              state_d = WRITE;
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            ovf_inc  = 1'b1;
            state_d  = s_axis_tlast ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
    endcase
  end

  // Two-stage read pipe (RAM register, then output register) so a stalled
  // consumer never loses the byte already fetched from RAM.
  assign drain       = tvalid_q & m_axis_tready;
  assign out_load    = ram_valid_q & (~tvalid_q | drain);
  assign fetch       = (rd_ptr_q != commit_ptr_q) & (~ram_valid_q | out_load);
  assign pending_dec = drain & tlast_q;

  always_ff @(posedge rx_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    if (fetch)  ram_rdata_q     <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q      <= SYNC;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      ram_valid_q  <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      if (fetch) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      ram_valid_q  <= fetch | (ram_valid_q & ~out_load);
      if (out_load) begin
        tlast_q <= ram_rdata_q[8];
        tdata_q <= ram_rdata_q[7:0];
      end
      tvalid_q <= out_load | (tvalid_q & ~drain);
      if (commit && !pending_dec)      pending_q <= pending_q + PEND_ONE;
      else if (!commit && pending_dec) pending_q <= pending_q - PEND_ONE;
    end
  end

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign frames_pending = pending_q;

`ifdef RXQ_STATS_EN
  logic [CNT_W-1:0] good_q, err_q, ovf_q;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      good_q <= '0;
      err_q  <= '0;
      ovf_q  <= '0;
    end else begin
      if (commit  && (good_q != '1)) good_q <= good_q + CNT_W'(1);
      if (err_inc && (err_q  != '1)) err_q  <= err_q  + CNT_W'(1);
      if (ovf_inc && (ovf_q  != '1)) ovf_q  <= ovf_q  + CNT_W'(1);
    end
  end

  assign stat_good = good_q;
  assign stat_err  = err_q;
  assign stat_ovf  = ovf_q;
`else
  logic unused_stat_events;
  assign unused_stat_events = err_inc | ovf_inc;
  assign stat_good = '0;
  assign stat_err  = '0;
  assign stat_ovf  = '0;
`endif

endmodule

// File: tb/tb_rx_frame_queue.sv
// Self-checking bench for rx_frame_queue: directed test plan plus randomized frames,
// checked against a frame-level reference model (queue of committed bytes).

module tb_rx_frame_queue;

  logic rx_clk = 1'b0;
  always #4 rx_clk = ~rx_clk;

  logic       rst;
  logic [7:0] inData;
  logic       inValid, inLast, inUser, outReady;
  bit         useSmall;

  logic [7:0]  bTdata, sTdata;
  logic        bTvalid, sTvalid, bTlast, sTlast;
  logic [11:0] bPend;
  logic [4:0]  sPend;
  logic [15:0] bGood, bErr, bOvf, sGood, sErr, sOvf;

  // Large instance for most tests, 16-byte instance for the overflow test.
  rx_frame_queue #(.ADDR_W(11), .CNT_W(16)) dutBig (
    .rx_clk(rx_clk), .rst(rst),
    .s_axis_tdata(inData), .s_axis_tvalid(inValid & ~useSmall),
    .s_axis_tlast(inLast), .s_axis_tuser(inUser),
    .m_axis_tdata(bTdata), .m_axis_tvalid(bTvalid),
    .m_axis_tready(outReady & ~useSmall), .m_axis_tlast(bTlast),
    .frames_pending(bPend), .stat_good(bGood), .stat_err(bErr), .stat_ovf(bOvf)
  );

  rx_frame_queue #(.ADDR_W(4), .CNT_W(16)) dutSmall (
    .rx_clk(rx_clk), .rst(rst),
    .s_axis_tdata(inData), .s_axis_tvalid(inValid & useSmall),
    .s_axis_tlast(inLast), .s_axis_tuser(inUser),
    .m_axis_tdata(sTdata), .m_axis_tvalid(sTvalid),
    .m_axis_tready(outReady & useSmall), .m_axis_tlast(sTlast),
    .frames_pending(sPend), .stat_good(sGood), .stat_err(sErr), .stat_ovf(sOvf)
  );

  logic [7:0]  obsData;
  logic        obsValid, obsLast;
  logic [11:0] obsPend;
  logic [15:0] obsGood, obsErr, obsOvf;

  assign obsData  = useSmall ? sTdata  : bTdata;
  assign obsValid = useSmall ? sTvalid : bTvalid;
  assign obsLast  = useSmall ? sTlast  : bTlast;
  assign obsPend  = useSmall ? {7'd0, sPend} : bPend;
  assign obsGood  = useSmall ? sGood : bGood;
  assign obsErr   = useSmall ? sErr  : bErr;
  assign obsOvf   = useSmall ? sOvf  : bOvf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: committed-but-not-consumed bytes, the frame under construction, counters.
  logic [8:0] expQ[$];
  logic [8:0] curFrame[$];
  int  modelPending, modelGood, modelErr, modelOvf;
  int  modelDepth = 2048;
  bit  inSync, dropping, skipCheck;

  bit         rV, rL, rU, rR, rHs;
  logic [7:0] rD;

  logic       sampValid;
  logic [7:0] sampData;
  logic [11:0] sampPending;
  bit         prevStall;
  logic [7:0] prevData;
  logic       prevLast;
  int         obsPeak;

  logic [7:0] frameBytes[$];

  function automatic logic [31:0] expStat(input int n);
`ifdef RXQ_STATS_EN
    return n;
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic logic readyFor(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cyc[0];
      default: return ($urandom_range(0, 9) < 7);
    endcase
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obsVal, input logic [31:0] expVal);
    checks++;
    assert (obsVal === expVal) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obsVal, expVal);
    end
  endtask

  task automatic checkOutput();
    sampValid   = obsValid;
    sampData    = obsData;
    sampPending = obsPend;
    rHs = 1'b0;
    if (skipCheck) begin
      prevStall = 1'b0;
      return;
    end
    if (int'(obsPend) > obsPeak) obsPeak = int'(obsPend);
    checkEq("frames_pending", obsPend, modelPending);
    checkEq("stat_good", obsGood, expStat(modelGood));
    checkEq("stat_err",  obsErr,  expStat(modelErr));
    checkEq("stat_ovf",  obsOvf,  expStat(modelOvf));
    if (prevStall) begin
      checkEq("stall_valid", obsValid, 1);
      checkEq("stall_data",  obsData,  prevData);
      checkEq("stall_last",  obsLast,  prevLast);
    end
    if (obsValid === 1'b1) begin
      if (expQ.size() == 0) checkEq("spurious_valid", obsValid, 0);
      else if (outReady) begin
        checkEq("out_beat", {obsLast, obsData}, expQ[0]);
        rHs = 1'b1;
      end
    end
    prevStall = (obsValid === 1'b1) && !outReady;
    prevData  = obsData;
    prevLast  = obsLast;
  endtask

  // Applies the rules for one clock edge at frame level. The reader is assumed
  // to have prefetched up to two committed bytes out of the RAM.
  task automatic modelEdge();
    int ahead, ramOcc;
    logic [8:0] popped;
    if (rR) begin
      expQ.delete(); curFrame.delete();
      inSync = 1; dropping = 0;
      modelPending = 0; modelGood = 0; modelErr = 0; modelOvf = 0;
      prevStall = 0;
      return;
    end
    if (inSync) begin
      if (!rV) inSync = 0;
    end else if (rV) begin
      if (dropping) begin
        if (rL) dropping = 0;
      end else begin
        ahead  = (expQ.size() < 2) ? expQ.size() : 2;
        ramOcc = expQ.size() + curFrame.size() - ahead;
        if (ramOcc >= modelDepth - 1) begin
          modelOvf++;
          curFrame.delete();
          dropping = !rL;
        end else if (rL) begin
          if (rU) modelErr++;
          else begin
            foreach (curFrame[i]) expQ.push_back(curFrame[i]);
            expQ.push_back({1'b1, rD});
            modelPending++;
            modelGood++;
          end
          curFrame.delete();
        end else begin
          curFrame.push_back({1'b0, rD});
        end
      end
    end
    if (rHs) begin
      popped = expQ.pop_front();
      if (popped[8]) modelPending--;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic u, input logic rdy, input logic r);
    inValid = v; inData = d; inLast = l; inUser = u; outReady = rdy; rst = r;
    #1;
    checkOutput();
    rV = v; rD = d; rL = l; rU = u; rR = r;
    @(posedge rx_clk);
    modelEdge();
    @(negedge rx_clk);
    cyc++;
  endtask

  task automatic idle(input int rmode);
    applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, readyFor(rmode), 1'b0);
  endtask

  task automatic doReset();
    skipCheck = 1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    skipCheck = 0;
    idle(1);
  endtask

  task automatic sendFrame(input logic [7:0] bytes[$], input logic user, input int rmode, input bit gaps);
    int n = bytes.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle(rmode);
      applyStimulus(1'b1, bytes[i], (i == n - 1),
                    (i == n - 1) ? user : 1'($urandom_range(0, 1)),
                    readyFor(rmode), 1'b0);
    end
  endtask

  task automatic drainQueue(input int rmode, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || sampValid === 1'b1) && n < budget) begin
      idle(rmode);
      n++;
    end
    checkEq("drain_done", expQ.size(), 0);
    repeat (4) idle(1);
  endtask

  initial begin
    string hello;
    rst = 1'b1; inValid = 1'b0; inData = '0; inLast = 1'b0; inUser = 1'b0; outReady = 1'b0;
    useSmall = 0;
    inSync = 1;
    @(negedge rx_clk);

    // Reset state
    doReset();
    checkEq("reset_tvalid", obsValid, 0);
    checkEq("reset_tdata",  obsData,  0);
    checkEq("reset_tlast",  obsLast,  0);
    checkEq("reset_pending", obsPend, 0);

    // Test 1: HELLO_FPGA, tvalid latency of two cycles after the commit edge
    hello = "HELLO_FPGA";
    frameBytes.delete();
    for (int i = 0; i < hello.len(); i++) frameBytes.push_back(hello[i]);
    sendFrame(frameBytes, 1'b0, 1, 0);
    idle(1); checkEq("t1_lat_1", sampValid, 0);
    idle(1); checkEq("t1_lat_2", sampValid, 0);
    idle(1); checkEq("t1_lat_3", sampValid, 1);
    checkEq("t1_first_byte", sampData, 8'h48);
    drainQueue(1, 200);
    checkEq("t1_stat_good", obsGood, expStat(1));
    checkEq("t1_pending_end", obsPend, 0);

    // Test 2: errored frame then a good 4-byte frame
    doReset();
    frameBytes.delete();
    for (int i = 0; i < 10; i++) frameBytes.push_back(8'(8'h10 + i));
    sendFrame(frameBytes, 1'b1, 1, 0);
    frameBytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    sendFrame(frameBytes, 1'b0, 1, 0);
    drainQueue(1, 200);
    checkEq("t2_stat_err",  obsErr,  expStat(1));
    checkEq("t2_stat_good", obsGood, expStat(1));

    // Test 4: three back-to-back 64-byte frames with tready toggling
    doReset();
    obsPeak = 0;
    for (int f = 0; f < 3; f++) begin
      frameBytes.delete();
      for (int i = 0; i < 64; i++) frameBytes.push_back(8'(f * 64 + i));
      sendFrame(frameBytes, 1'b0, 2, 0);
    end
    drainQueue(2, 600);
    checkEq("t4_pending_peak", obsPeak, 3);
    checkEq("t4_pending_end", obsPend, 0);

    // Test 5: reset at byte 5 of a 20-byte frame with tvalid continuous
    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 8'(8'h30 + i), (i == 19), 1'b0, 1'b1, (i == 4));
    idle(1);
    frameBytes = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    sendFrame(frameBytes, 1'b0, 1, 0);
    drainQueue(1, 200);
    checkEq("t5_stat_good", obsGood, expStat(1));

    // Test 6: single-byte frame
    doReset();
    frameBytes = '{8'h7E};
    sendFrame(frameBytes, 1'b0, 1, 0);
    idle(1);
    checkEq("t6_pending_commit", sampPending, 1);
    drainQueue(1, 50);
    checkEq("t6_pending_end", obsPend, 0);

    // Test 3: 16-byte buffer, second frame overflows while tready is low
    useSmall = 1;
    modelDepth = 16;
    doReset();
    frameBytes.delete();
    for (int i = 0; i < 10; i++) frameBytes.push_back(8'(8'h50 + i));
    sendFrame(frameBytes, 1'b0, 0, 0);
    repeat (3) idle(0);
    frameBytes.delete();
    for (int i = 0; i < 8; i++) frameBytes.push_back(8'(8'h60 + i));
    sendFrame(frameBytes, 1'b0, 0, 0);
    repeat (3) idle(0);
    checkEq("t3_stat_ovf", obsOvf, expStat(1));
    checkEq("t3_pending", obsPend, 1);
    drainQueue(1, 100);
    frameBytes = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74};
    sendFrame(frameBytes, 1'b0, 1, 0);
    drainQueue(1, 100);
    checkEq("t3_stat_good", obsGood, expStat(2));

    // Randomized frames: lengths, tuser, gaps and tready all random
    useSmall = 0;
    modelDepth = 2048;
    doReset();
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, 40);
      frameBytes.delete();
      for (int i = 0; i < len; i++) frameBytes.push_back(8'($urandom));
      sendFrame(frameBytes, 1'($urandom_range(0, 4) == 0), 3, 1);
      repeat ($urandom_range(0, 2)) idle(3);
    end
    drainQueue(3, 3000);
    checkEq("rand_pending_end", obsPend, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_queue.md
Name: rx_frame_queue

Overview:
- Store-and-forward frame queue between the mac_rx AXI-Stream output and downstream consumers (parser, DMA), all in the rx_clk domain.
- mac_rx has no backpressure, so this block accepts every input beat unconditionally.
- A frame becomes visible downstream only after its last byte arrives with no error flag. Errored or overflowing frames are rolled back and never emitted.
- Output is AXI-Stream with full tready backpressure.

Parameters:
- ADDR_W, 11, log2 of buffer depth in bytes (DEPTH = 2**ADDR_W).
- CNT_W, 16, width of the statistics counters.

Ports:
- rx_clk  in  1  clock (125 MHz).
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  byte from mac_rx.
- s_axis_tvalid  in  1  beat valid; no tready, so a beat is consumed every valid cycle.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  frame error; sampled only on the tlast beat.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last byte of frame.
- frames_pending  out  ADDR_W+1  committed frames not yet fully emitted.
- stat_good  out  CNT_W  frames committed.
- stat_err  out  CNT_W  frames dropped because tuser=1.
- stat_ovf  out  CNT_W  frames dropped for lack of space.

Behaviour:
- Storage: DEPTH x 9-bit RAM holding {tlast, data}, synchronous read with 1-cycle latency.
- Pointers (ADDR_W bits, wrap modulo DEPTH):
  - wr_ptr: next address to write.
  - commit_ptr: end of the last committed frame.
  - rd_ptr: next address to fetch.
- Full condition: wr_ptr+1 == rd_ptr. One slot is always left empty.
- Reset: all pointers 0, frames_pending 0, counters 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, write FSM in SYNC.
- Write FSM states SYNC, IDLE, WRITE, DROP:
  - SYNC: discard beats. Go to IDLE on the first cycle with s_axis_tvalid=0. This prevents committing a partial frame caught mid-way at reset release.
  - IDLE/WRITE, valid beat, not full: write the byte at wr_ptr, then wr_ptr+1.
    - If tlast and tuser=0: commit_ptr <= wr_ptr+1, increment frames_pending and stat_good, go to IDLE.
    - If tlast and tuser=1: wr_ptr <= commit_ptr (rollback), increment stat_err, go to IDLE.
    - Otherwise go to WRITE.
  - IDLE/WRITE, valid beat, full: wr_ptr <= commit_ptr, increment stat_ovf.
    - If this beat is tlast, go to IDLE; otherwise go to DROP.
    - The overflowing beat is never written.
  - DROP: discard beats. Go to IDLE after the tlast beat.
  - Gaps in s_axis_tvalid inside a frame are legal in WRITE and DROP.
- Single-beat frame (tlast on the first beat, tuser=0): a valid 1-byte frame, committed.
- Read side:
  - Fetch from rd_ptr while rd_ptr != commit_ptr and the output register is empty or being drained (tvalid && tready).
  - rd_ptr advances on each fetch, which frees that slot for the writer.
  - Read data lands in the output register one cycle after fetch.
  - m_axis_tvalid rises exactly 2 cycles after the commit edge when the output path is idle.
  - With tready held high, sustained throughput is 1 byte per cycle (back-to-back fetches).
- Output holds stable while tvalid=1 and tready=0.
- frames_pending decrements on the handshake of a tlast beat.
- Commit and output tlast handshake in the same cycle: frames_pending stays unchanged (net 0).
- Writer rollback never moves wr_ptr below commit_ptr; the read side never passes commit_ptr.
- Counters saturate at all-ones.
- Reset mid-operation discards all buffered and in-flight data.

Optional Feature:
- RXQ_STATS_EN defined: stat_good, stat_err and stat_ovf count as described.
- RXQ_STATS_EN undefined: counter logic is removed and the three ports are tied to 0. The ports remain present.

Test Plan:
1. 10-byte frame 0x48..0x41 ("HELLO_FPGA"), tuser=0, tready=1 -> the 10 bytes appear in order, tlast on byte 10, tvalid rises 2 cycles after the input tlast beat; stat_good=1, frames_pending returns to 0.
2. 10-byte frame with tuser=1 on tlast, followed by a good 4-byte frame 0xA1..0xA4 -> only 0xA1..0xA4 emitted; stat_err=1, stat_good=1.
3. ADDR_W=4 (15 usable bytes), tready=0, frames of 10 then 8 bytes -> second frame dropped with stat_ovf=1. Then release tready -> only the first frame emitted, and a following 5-byte frame is accepted and emitted.
4. Three back-to-back 64-byte frames, tready toggling 1/0 every cycle -> all 192 bytes in order, tdata stable while stalled, frames_pending peaks at 3 and ends at 0.
5. Assert rst for 1 cycle at byte 5 of a 20-byte frame, tvalid continuous -> remaining 15 bytes discarded (SYNC), nothing emitted, a following frame after a 1-cycle idle gap is emitted intact.
6. 1-byte frame 0x7E (tlast on the first beat) -> single output beat 0x7E with tlast=1, frames_pending 1 then 0.
